gbf_fill_ctrl: RTL and testbench
================================

GBF_FILL_CTRL -- requirements
Module: gbf_fill_ctrl

Interface
REQ-001 SHALL have parameter GBF_DATA_BITWIDTH, default 512, meaning GBF line width in bits.
REQ-002 SHALL have parameter GBF_ADDR_BITWIDTH, default 5, meaning GBF address width.
REQ-003 SHALL have parameter GBF_DEPTH, default 32, meaning lines per GBF bank.
REQ-004 SHALL have parameter SRC_BITWIDTH, default 64, meaning upstream beat width; GBF_DATA_BITWIDTH/SRC_BITWIDTH (BEATS, default 8) SHALL be an integer.
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk  in  1  clock, rising edge; reset  in  1  asynchronous reset, active low (0 = reset).
REQ-006 SHALL have these ports: s_valid  in  1  upstream beat valid; s_ready  out  1  beat accepted when s_valid&s_ready; s_data  in  SRC_BITWIDTH  beat payload.
REQ-007 SHALL have these ports: fill_lines  in  GBF_ADDR_BITWIDTH+1  lines per fill; need_data1/need_data2  in  1 each  from gbf_controller, bank consumed.
REQ-008 SHALL have these ports: en1a/we1a/en2a/we2a  out  1 each  bank port-a strobes; addr1a/addr2a  out  GBF_ADDR_BITWIDTH; w_data1a/w_data2a  out  GBF_DATA_BITWIDTH.
REQ-009 SHALL have these ports: buf1_ready/buf2_ready  out  1 each  bank full; data_avail  out  1  = buf1_ready|buf2_ready.

Function
REQ-010 SHALL implement FSM IDLE -> FILL -> WRITE -> (FILL | IDLE), with target-bank pointer tgt (1 or 2).
REQ-011 IDLE -> FILL SHALL occur when bank tgt is empty (its bufX_ready=0), sampling fill_lines; fill_lines=0 SHALL mean GBF_DEPTH, and values >GBF_DEPTH SHALL clamp to GBF_DEPTH.
REQ-012 In FILL, s_ready SHALL be 1; each accepted beat k (0..BEATS-1) SHALL be packed into line bits [k*SRC_BITWIDTH +: SRC_BITWIDTH], beat 0 = LSBs.
REQ-013 On acceptance of beat BEATS-1, the packed line SHALL be registered and the FSM SHALL enter WRITE.
REQ-014 WRITE SHALL last exactly one cycle with enXa=weXa=1 for bank tgt only, addrXa=line index, w_dataXa=registered line; the non-target bank's strobes SHALL remain 0.
REQ-015 In WRITE, s_ready SHALL remain 1 if more lines remain, with the accepted beat becoming beat 0 of the next line, so sustained throughput is 1 beat/cycle; s_ready SHALL be 0 in IDLE and in the WRITE of the final line.
REQ-016 Line index SHALL start at 0 and increment after each WRITE; after the WRITE of line fill_lines-1: bufX_ready(tgt)<=1, tgt toggles, and the FSM returns to IDLE.
REQ-017 bufX_ready SHALL stay 1 until needX_data is sampled 1, then clear on the next edge; needX_data SHALL be ignored while bufX_ready=0.
REQ-018 Simultaneous need_data1 and need_data2 SHALL clear both ready flags in the same cycle.
REQ-019 Banks SHALL be filled strictly alternately, starting with bank 1 after reset; if tgt is still full, the FSM SHALL wait in IDLE even if the other bank is empty.
REQ-020 en/we SHALL be 0 in all states except WRITE; addr/w_data SHALL hold their last values outside WRITE.

Reset
REQ-021 While reset=0, all of the following SHALL be 0: s_ready, en*, we*, addr*, w_data*, buf*_ready, data_avail; the FSM SHALL be IDLE, tgt=1, and the beat and line counters SHALL be 0.
REQ-022 Assertion of reset mid-fill SHALL discard the partial line and bank contents status; no write strobe SHALL occur after reset releases until a new FILL completes a line.

Configuration
REQ-023 With macro GBF_FILL_STALL_CNT_EN defined, the block SHALL add output stall_cnt [15:0], reset to 0, incrementing (saturating at 16'hFFFF) each cycle in FILL/WRITE with s_ready=1 and s_valid=0; without the macro, the port and logic SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-024 Reset, fill_lines=2, 16 beats data=beat index -> bank1 writes at addr 0 then 1; line0 = {64'h7,...,64'h0}; buf1_ready=1 and data_avail=1 one cycle after the second WRITE.
REQ-025 Continuous s_valid, fill_lines=0 -> 256 beats, 32 bank1 writes (addr 0..31), completing in 256 cycles plus 1; then the next fill targets bank2.
REQ-026 Both banks full, pulse need_data2 -> FSM stays IDLE (tgt=1 full); then pulse need_data1 -> buf1_ready drops next edge and bank1 refill starts.
REQ-027 need_data1 and need_data2 asserted in the same cycle while both are ready -> both ready flags clear together and data_avail=0.
REQ-028 reset=0 after beat 5 of line 3 -> all outputs 0 immediately; after release, the next write is bank1 addr 0.
REQ-029 With GBF_FILL_STALL_CNT_EN, 4 idle s_valid cycles inserted mid-line -> stall_cnt=4.

Source files
------------

// File: rtl/gbf_fill_ctrl.sv
// gbf_fill_ctrl: packs SRC_BITWIDTH upstream beats into GBF lines and fills
// two ping-pong GBF banks strictly alternately, starting with bank 1.
// Optional feature macro: GBF_FILL_STALL_CNT_EN adds the stall_cnt output.
module gbf_fill_ctrl #(
    parameter int unsigned GBF_DATA_BITWIDTH = 512,
    parameter int unsigned GBF_ADDR_BITWIDTH = 5,
    parameter int unsigned GBF_DEPTH         = 32,
    parameter int unsigned SRC_BITWIDTH      = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [SRC_BITWIDTH-1:0]      s_data,
    input  logic [GBF_ADDR_BITWIDTH:0]   fill_lines,
    input  logic                         need_data1,
    input  logic                         need_data2,
    output logic                         en1a,
    output logic                         we1a,
    output logic                         en2a,
    output logic                         we2a,
    output logic [GBF_ADDR_BITWIDTH-1:0] addr1a,
    output logic [GBF_ADDR_BITWIDTH-1:0] addr2a,
    output logic [GBF_DATA_BITWIDTH-1:0] w_data1a,
    output logic [GBF_DATA_BITWIDTH-1:0] w_data2a,
    output logic                         buf1_ready,
    output logic                         buf2_ready,
    output logic                         data_avail
`ifdef GBF_FILL_STALL_CNT_EN
    ,
    output logic [15:0]                  stall_cnt
`endif
);

    localparam int unsigned BEATS  = GBF_DATA_BITWIDTH / SRC_BITWIDTH;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned LINE_W = GBF_ADDR_BITWIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t                       state, state_nxt;
    logic                         tgt2, tgt2_nxt;          // 0 = bank 1, 1 = bank 2
    logic [BEAT_W-1:0]            beat_cnt, beat_nxt;
    logic [LINE_W-1:0]            line_cnt, line_nxt;
    logic [LINE_W-1:0]            n_lines, n_lines_nxt;
    logic [LINE_W-1:0]            fill_clamp;
    logic [GBF_DATA_BITWIDTH-1:0] line_buf, line_buf_nxt;
    logic                         buf1_nxt, buf2_nxt;
    logic                         s_ready_nxt;
    logic                         wr_go;
    logic                         accept;
    logic                         last_beat;
    logic                         last_line;
    logic                         tgt_full;

    // Next-state, beat packing, bank bookkeeping and next output values
    always_comb begin
        state_nxt    = state;
        tgt2_nxt     = tgt2;
        beat_nxt     = beat_cnt;
        line_nxt     = line_cnt;
        n_lines_nxt  = n_lines;
        line_buf_nxt = line_buf;
        buf1_nxt     = buf1_ready;
        buf2_nxt     = buf2_ready;
        fill_clamp   = fill_lines;
        accept       = s_valid & s_ready;
        last_beat    = (beat_cnt == BEAT_W'(BEATS - 1));
        last_line    = (line_cnt == (n_lines - LINE_W'(1)));
        tgt_full     = tgt2 ? buf2_ready : buf1_ready;

        // zero means a full bank; oversize requests are clamped to the bank depth
        if ((fill_lines == '0) || (fill_lines > LINE_W'(GBF_DEPTH))) begin
            fill_clamp = LINE_W'(GBF_DEPTH);
        end

        // a consume request only matters while the bank is full
        if (need_data1 && buf1_ready) begin
            buf1_nxt = 1'b0;
        end
        if (need_data2 && buf2_ready) begin
            buf2_nxt = 1'b0;
        end

        unique case (state)
            IDLE: begin
                if (!tgt_full) begin
                    state_nxt   = FILL;
                    n_lines_nxt = fill_clamp;
                    line_nxt    = '0;
                    beat_nxt    = '0;
                end
            end
            FILL: begin
            end
            WRITE: begin
                if (last_line) begin
                    state_nxt = IDLE;
                    line_nxt  = '0;
                    tgt2_nxt  = ~tgt2;
                    if (tgt2) begin
                        buf2_nxt = 1'b1;
                    end else begin
                        buf1_nxt = 1'b1;
                    end
                end else begin
                    state_nxt = FILL;
                    line_nxt  = line_cnt + LINE_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        // beats are taken in FILL and in non-final WRITE; beat 0 lands in the LSBs
        if (accept && (state != IDLE)) begin
            for (int unsigned k = 0; k < BEATS; k++) begin
                if (beat_cnt == BEAT_W'(k)) begin
                    line_buf_nxt[k*SRC_BITWIDTH +: SRC_BITWIDTH] = s_data;
                end
            end
            if (last_beat) begin
                state_nxt = WRITE;
                beat_nxt  = '0;
            end else begin
                beat_nxt = beat_cnt + BEAT_W'(1);
            end
        end

        wr_go       = (state_nxt == WRITE);
        s_ready_nxt = (state_nxt == FILL) ||
                      ((state_nxt == WRITE) && (line_nxt != (n_lines_nxt - LINE_W'(1))));
    end

    // State register and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            tgt2       <= 1'b0;
            beat_cnt   <= '0;
            line_cnt   <= '0;
            n_lines    <= '0;
            line_buf   <= '0;
            s_ready    <= 1'b0;
            en1a       <= 1'b0;
            we1a       <= 1'b0;
            en2a       <= 1'b0;
            we2a       <= 1'b0;
            addr1a     <= '0;
            addr2a     <= '0;
            w_data1a   <= '0;
            w_data2a   <= '0;
            buf1_ready <= 1'b0;
            buf2_ready <= 1'b0;
            data_avail <= 1'b0;
        end else begin
            state      <= state_nxt;
            tgt2       <= tgt2_nxt;
            beat_cnt   <= beat_nxt;
            line_cnt   <= line_nxt;
            n_lines    <= n_lines_nxt;
            line_buf   <= line_buf_nxt;
            s_ready    <= s_ready_nxt;
            en1a       <= wr_go & ~tgt2_nxt;
            we1a       <= wr_go & ~tgt2_nxt;
            en2a       <= wr_go & tgt2_nxt;
            we2a       <= wr_go & tgt2_nxt;
            buf1_ready <= buf1_nxt;
            buf2_ready <= buf2_nxt;
            data_avail <= buf1_nxt | buf2_nxt;
            if (wr_go && !tgt2_nxt) begin
                addr1a   <= line_nxt[GBF_ADDR_BITWIDTH-1:0];
                w_data1a <= line_buf_nxt;
            end
            if (wr_go && tgt2_nxt) begin
                addr2a   <= line_nxt[GBF_ADDR_BITWIDTH-1:0];
                w_data2a <= line_buf_nxt;
            end
        end
    end

`ifdef GBF_FILL_STALL_CNT_EN
    // Count cycles where the block could take a beat but the source had none
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if ((state != IDLE) && s_ready && !s_valid && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gbf_fill_ctrl.sv
// tb_gbf_fill_ctrl: table-driven fill-size sweep, directed ping-pong/reset
// sequences and randomized fills checked against a beat-stream model.
module tb_gbf_fill_ctrl;

    localparam int unsigned DW    = 512;
    localparam int unsigned AW    = 5;
    localparam int unsigned SW    = 64;
    localparam int unsigned BEATS = DW / SW;

    logic          clk;
    logic          reset;
    logic          s_valid;
    logic          s_ready;
    logic [SW-1:0] s_data;
    logic [AW:0]   fill_lines;
    logic          need_data1;
    logic          need_data2;
    logic          en1a, we1a, en2a, we2a;
    logic [AW-1:0] addr1a, addr2a;
    logic [DW-1:0] w_data1a, w_data2a;
    logic          buf1_ready, buf2_ready, data_avail;
`ifdef GBF_FILL_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    gbf_fill_ctrl dut (
`ifdef GBF_FILL_STALL_CNT_EN
        .stall_cnt  (stall_cnt),
`endif
        .clk        (clk),
        .reset      (reset),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .fill_lines (fill_lines),
        .need_data1 (need_data1),
        .need_data2 (need_data2),
        .en1a       (en1a),
        .we1a       (we1a),
        .en2a       (en2a),
        .we2a       (we2a),
        .addr1a     (addr1a),
        .addr2a     (addr2a),
        .w_data1a   (w_data1a),
        .w_data2a   (w_data2a),
        .buf1_ready (buf1_ready),
        .buf2_ready (buf2_ready),
        .data_avail (data_avail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          bank2;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic [AW:0] fl;
        int          lines;
    } tab_t;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [SW-1:0] acc_q[$];
    wr_t         wr_q[$];
    tab_t        tab[7];
    bit          rand_run;
    int          rl;
    int          rc;
    int          idx;
    int          cyc;
    int          nrdy;
    logic        rdy;

    function automatic void check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // expected line j: beats j*BEATS .. j*BEATS+BEATS-1 of the accepted stream, beat 0 in LSBs
    function automatic logic [DW-1:0] pack_line(input int j);
        logic [DW-1:0] l;
        l = '0;
        for (int k = 0; k < BEATS; k++) begin
            if (j * BEATS + k < acc_q.size()) l[k*SW +: SW] = acc_q[j*BEATS + k];
        end
        return l;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // record every bank write; exactly one bank's en/we pair may be active
    always @(negedge clk) begin
        if (reset && (en1a || we1a || en2a || we2a)) begin
            wr_t w;
            check("strobe_pair", DW'({en1a, we1a, en2a, we2a}),
                  DW'((en1a || we1a) ? 4'b1100 : 4'b0011));
            w.bank2 = en2a;
            w.addr  = en2a ? addr2a : addr1a;
            w.data  = en2a ? w_data2a : w_data1a;
            wr_q.push_back(w);
        end
    end

    task automatic do_reset();
        reset      = 1'b0;
        s_valid    = 1'b0;
        need_data1 = 1'b0;
        need_data2 = 1'b0;
        #1;
        check("rst_ctrl", DW'({s_ready, en1a, we1a, en2a, we2a, buf1_ready, buf2_ready, data_avail}), '0);
        check("rst_addr", DW'({addr1a, addr2a}), '0);
        check("rst_wdata", w_data1a | w_data2a, '0);
`ifdef GBF_FILL_STALL_CNT_EN
        check("rst_stall", DW'(stall_cnt), '0);
`endif
        tick();
        tick();
        reset = 1'b1;
        wr_q.delete();
        acc_q.delete();
    endtask

    // present n beats base, base+1, ... with s_valid held high until all are taken
    task automatic send_beats(input int n, input logic [SW-1:0] base);
        int   i;
        int   guard;
        logic r;
        i = 0;
        guard = 0;
        while (i < n && guard < 2000) begin
            s_valid = 1'b1;
            s_data  = base + SW'(i);
            r       = s_ready;
            tick();
            guard++;
            if (r) begin
                acc_q.push_back(s_data);
                i++;
            end
        end
        s_valid = 1'b0;
        check("send_done", DW'(i == n), DW'(1));
    endtask

    task automatic src_rand();
        logic [SW-1:0] d;
        logic          r;
        d = {$urandom, $urandom};
        while (rand_run) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = d;
            r       = s_ready;
            tick();
            if (s_valid && r) begin
                acc_q.push_back(d);
                d = {$urandom, $urandom};
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic cons_rand();
        while (rand_run) begin
            need_data1 = ($urandom_range(0, 3) == 0);
            need_data2 = ($urandom_range(0, 3) == 0);
            tick();
        end
        need_data1 = 1'b0;
        need_data2 = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tab[0] = '{6'd1,  1};
        tab[1] = '{6'd2,  2};
        tab[2] = '{6'd7,  7};
        tab[3] = '{6'd0,  32};
        tab[4] = '{6'd32, 32};
        tab[5] = '{6'd33, 32};
        tab[6] = '{6'd63, 32};

        reset      = 1'b1;
        s_valid    = 1'b0;
        s_data     = '0;
        fill_lines = '0;
        need_data1 = 1'b0;
        need_data2 = 1'b0;
        #2;

        // fill-size sweep: IDLE->FILL edge, lines*BEATS beat cycles, final WRITE, then ready
        for (int t = 0; t < 7; t++) begin
            do_reset();
            fill_lines = tab[t].fl;
            s_valid = 1'b1;
            idx = 0;
            cyc = 0;
            nrdy = 0;
            while (!buf1_ready && cyc < 400) begin
                s_data = {32'(t), 32'(idx)};
                rdy = s_ready;
                if (rdy) nrdy++;
                tick();
                cyc++;
                if (rdy) begin
                    acc_q.push_back(s_data);
                    idx++;
                end
            end
            s_valid = 1'b0;
            check($sformatf("tab%0d_cycles", t), DW'(cyc), DW'(tab[t].lines * BEATS + 2));
            check($sformatf("tab%0d_beats", t), DW'(nrdy), DW'(tab[t].lines * BEATS));
            check($sformatf("tab%0d_writes", t), DW'(wr_q.size()), DW'(tab[t].lines));
            if (wr_q.size() == tab[t].lines) begin
                check($sformatf("tab%0d_first", t), DW'({wr_q[0].bank2, wr_q[0].addr}), '0);
                check($sformatf("tab%0d_last_addr", t), DW'(wr_q[tab[t].lines-1].addr), DW'(tab[t].lines - 1));
                check($sformatf("tab%0d_last_data", t), wr_q[tab[t].lines-1].data, pack_line(tab[t].lines - 1));
            end
        end

        // two-line fill of bank 1 with data = beat index
        do_reset();
        fill_lines = 6'd2;
        send_beats(16, 64'd0);
        check("w2_strobe", DW'({en1a, we1a, en2a, s_ready}), DW'(4'b1100));
        check("w2_addr", DW'(addr1a), DW'(1));
        fill_lines = 6'd1;
        tick();
        check("w2_ready", DW'({buf1_ready, buf2_ready, data_avail}), DW'(3'b101));
        if (wr_q.size() == 2) begin
            logic [DW-1:0] e0, e1;
            for (int k = 0; k < BEATS; k++) begin
                e0[k*SW +: SW] = SW'(k);
                e1[k*SW +: SW] = SW'(k + BEATS);
            end
            check("line0_hdr", DW'({wr_q[0].bank2, wr_q[0].addr}), DW'(0));
            check("line0_data", wr_q[0].data, e0);
            check("line1_hdr", DW'({wr_q[1].bank2, wr_q[1].addr}), DW'(1));
            check("line1_data", wr_q[1].data, e1);
        end else begin
            check("w2_count", DW'(wr_q.size()), DW'(2));
        end

        // next fill targets bank 2
        send_beats(8, 64'd100);
        tick();
        check("b2_ready", DW'({buf1_ready, buf2_ready, data_avail}), DW'(3'b111));
        check("b2_count", DW'(wr_q.size()), DW'(3));
        if (wr_q.size() == 3) begin
            check("b2_hdr", DW'({wr_q[2].bank2, wr_q[2].addr}), DW'({1'b1, 5'd0}));
            check("b2_data", wr_q[2].data, pack_line(2));
        end

        // both full: freeing bank 2 must not start a fill while bank 1 (target) is full
        tick();
        tick();
        check("full_idle", DW'(s_ready), DW'(0));
        need_data2 = 1'b1;
        tick();
        need_data2 = 1'b0;
        check("n2_clear", DW'({buf1_ready, buf2_ready, data_avail}), DW'(3'b101));
        tick();
        tick();
        tick();
        check("n2_wait", DW'({s_ready, wr_q.size() == 3}), DW'(2'b01));
        need_data1 = 1'b1;
        tick();
        need_data1 = 1'b0;
        check("n1_clear", DW'({buf1_ready, buf2_ready, data_avail}), DW'(3'b000));
        tick();
        check("n1_refill", DW'(s_ready), DW'(1));
        send_beats(8, 64'd200);
        tick();
        send_beats(8, 64'd300);
        tick();
        check("refill_ready", DW'({buf1_ready, buf2_ready, data_avail}), DW'(3'b111));
        check("refill_count", DW'(wr_q.size()), DW'(5));
        if (wr_q.size() == 5) begin
            check("refill1", {DW'({wr_q[3].bank2, wr_q[3].addr}) ^ wr_q[3].data}, DW'(0) ^ pack_line(3));
            check("refill2", DW'({wr_q[4].bank2, wr_q[4].addr}), DW'({1'b1, 5'd0}));
        end

        // simultaneous consume of both banks
        need_data1 = 1'b1;
        need_data2 = 1'b1;
        tick();
        need_data1 = 1'b0;
        need_data2 = 1'b0;
        check("both_clear", DW'({buf1_ready, buf2_ready, data_avail}), DW'(3'b000));

        // reset after beat 5 of line 3, then a fresh fill lands in bank 1 addr 0
        do_reset();
        fill_lines = 6'd4;
        send_beats(3 * BEATS + 6, 64'd1000);
        check("mid_writes", DW'(wr_q.size()), DW'(3));
        fill_lines = 6'd1;
        do_reset();
        tick();
        tick();
        tick();
        check("post_rst_nowr", DW'(wr_q.size()), DW'(0));
        send_beats(8, 64'd2000);
        tick();
        check("post_rst_count", DW'(wr_q.size()), DW'(1));
        if (wr_q.size() == 1) begin
            check("post_rst_hdr", DW'({wr_q[0].bank2, wr_q[0].addr}), DW'(0));
            check("post_rst_data", wr_q[0].data, pack_line(0));
        end

`ifdef GBF_FILL_STALL_CNT_EN
        // four idle source cycles mid-line
        do_reset();
        fill_lines = 6'd1;
        send_beats(3, 64'd0);
        tick();
        tick();
        tick();
        tick();
        send_beats(5, 64'd3);
        tick();
        check("stall_cnt", DW'(stall_cnt), DW'(4));
`endif

        // random traffic: writes must follow the accepted stream, banks alternating
        for (int r = 0; r < 3; r++) begin
            do_reset();
            rl = $urandom_range(1, 4);
            fill_lines = (AW+1)'(rl);
            rand_run = 1'b1;
            rc = 0;
            fork
                src_rand();
                cons_rand();
                begin
                    while (wr_q.size() < 5 * rl && rc < 4000) begin
                        tick();
                        rc++;
                    end
                    rand_run = 1'b0;
                end
            join
            check($sformatf("rnd%0d_done", r), DW'(wr_q.size() >= 5 * rl), DW'(1));
            for (int j = 0; j < wr_q.size(); j++) begin
                check($sformatf("rnd%0d_bank_%0d", r, j), DW'(wr_q[j].bank2), DW'((j / rl) % 2));
                check($sformatf("rnd%0d_addr_%0d", r, j), DW'(wr_q[j].addr), DW'(j % rl));
                check($sformatf("rnd%0d_data_%0d", r, j), wr_q[j].data, pack_line(j));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
